// File: rtl/ewrapper_tx_sched_pkg.sv
// rtl/ewrapper_tx_sched_pkg.sv - shared frame, state and transaction-field constants
package ewrapper_tx_sched_pkg;

  localparam int TRAN_W = 104;
  localparam int WORD_W = 72;
  localparam int CNT_W  = 16;

  localparam logic [7:0] FRAME_START = 8'h3F;
  localparam logic [7:0] FRAME_BODY  = 8'hFF;
  localparam logic [7:0] FRAME_IDLE  = 8'h00;

  // Transaction layout {ctrl[7:0], dst[31:0], data[31:0], src[31:0]}, MSB first.
  localparam int CTRL_LSB = 96;
  localparam int DST_LSB  = 64;
  localparam int DATA_LSB = 32;
  localparam int SRC_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } tx_state_e;

endpackage

// File: rtl/ewrapper_rr_arb2.sv
// rtl/ewrapper_rr_arb2.sv - two-way round-robin arbiter with a preferred-requester pointer
module ewrapper_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic ptr_q;
  logic ptr_d;

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    if (req_i == 2'b11) begin
      grant_o = ptr_q ? 2'b10 : 2'b01;
    end else begin
      grant_o = req_i;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && (grant_o != 2'b00)) begin
      ptr_d = grant_o[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ewrapper_tx_sched.sv
// rtl/ewrapper_tx_sched.sv - two-requester transaction scheduler packing 104-bit transactions into 72-bit beats
module ewrapper_tx_sched
  import ewrapper_tx_sched_pkg::*;
(
  input  logic                CLK_DIV_IN,
  input  logic                RESET,
  input  logic                TX_WAIT,
  input  logic                VALID0,
  input  logic [TRAN_W-1:0]   TRAN0,
  output logic                READY0,
  input  logic                VALID1,
  input  logic [TRAN_W-1:0]   TRAN1,
  output logic                READY1,
  output logic [WORD_W-1:0]   DATA_OUT_FROM_DEVICE,
  output logic                BUSY,
  output logic [CNT_W-1:0]    TX_COUNT
);

  tx_state_e         state_q;
  tx_state_e         state_d;
  logic [TRAN_W-1:0] hold_q;
  logic [TRAN_W-1:0] hold_d;
  logic [WORD_W-1:0] dout_q;
  logic [WORD_W-1:0] dout_d;
  logic [CNT_W-1:0]  tx_count_q;
  logic [CNT_W-1:0]  tx_count_d;
  logic [1:0]        grant;
  logic              accept;
  logic [TRAN_W-1:0] sel_tran;

  function automatic logic [WORD_W-1:0] pack_word(input tx_state_e beat, input logic [TRAN_W-1:0] t);
    if (beat == ST_BEAT0) begin
      return {FRAME_START, t[CTRL_LSB +: 8], t[DST_LSB +: 32], t[DATA_LSB + 8 +: 24]};
    end
    return {FRAME_BODY, t[DATA_LSB +: 8], t[SRC_LSB +: 32], 24'h0};
  endfunction

  // Reset suppresses accept so no READY can escape in a reset cycle.
  assign accept   = (state_q == ST_IDLE) & ~TX_WAIT & (VALID0 | VALID1) & ~RESET;
  assign sel_tran = grant[1] ? TRAN1 : TRAN0;

  ewrapper_rr_arb2 u_arb (
    .clk_i     (CLK_DIV_IN),
    .rst_i     (RESET),
    .req_i     ({VALID1, VALID0}),
    .advance_i (accept),
    .grant_o   (grant)
  );

  always_ff @(posedge CLK_DIV_IN) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_BEAT0;
      ST_BEAT0: state_d = ST_BEAT1;
      ST_BEAT1: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // TX_WAIT is only consulted through accept, so a beat in flight is never stalled.
  always_comb begin
    READY0     = accept & grant[0];
    READY1     = accept & grant[1];
    hold_d     = hold_q;
    dout_d     = {FRAME_IDLE, 64'h0};
    tx_count_d = tx_count_q;
    if (accept) begin
      hold_d     = sel_tran;
      dout_d     = pack_word(ST_BEAT0, sel_tran);
      tx_count_d = tx_count_q + 16'd1;
    end else if (state_q == ST_BEAT0) begin
      dout_d     = pack_word(ST_BEAT1, hold_q);
    end
  end

  always_ff @(posedge CLK_DIV_IN) begin
    if (RESET) begin
      hold_q     <= '0;
      dout_q     <= '0;
      tx_count_q <= '0;
    end else begin
      hold_q     <= hold_d;
      dout_q     <= dout_d;
      tx_count_q <= tx_count_d;
    end
  end

  assign DATA_OUT_FROM_DEVICE = dout_q;
  assign BUSY                 = (state_q != ST_IDLE);
  assign TX_COUNT             = tx_count_q;

endmodule

// File: tb/tb_ewrapper_tx_sched.sv
// tb/tb_ewrapper_tx_sched.sv - vector, corner-case and randomized model checks for ewrapper_tx_sched
module tb_ewrapper_tx_sched;

  logic         clk = 1'b0;
  logic         rst, tx_wait, v0, v1;
  logic [103:0] t0, t1;
  logic         r0, r1, busy;
  logic [71:0]  dout;
  logic [15:0]  cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ewrapper_tx_sched dut (
    .CLK_DIV_IN           (clk),
    .RESET                (rst),
    .TX_WAIT              (tx_wait),
    .VALID0               (v0),
    .TRAN0                (t0),
    .READY0               (r0),
    .VALID1               (v1),
    .TRAN1                (t1),
    .READY1               (r1),
    .DATA_OUT_FROM_DEVICE (dout),
    .BUSY                 (busy),
    .TX_COUNT             (cnt)
  );

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic drive(input logic r, input logic w, input logic a, input logic b,
                       input logic [103:0] ta, input logic [103:0] tb_);
    rst = r; tx_wait = w; v0 = a; v1 = b; t0 = ta; t1 = tb_;
  endtask

  // Wire-order word: {frame, lanes 7..0}
  function automatic logic [71:0] beat0_of(input logic [103:0] t);
    logic [7:0] ctrl; logic [31:0] dst, data;
    ctrl = t[103:96]; dst = t[95:64]; data = t[63:32];
    return {8'h3F, ctrl, dst, data[31:8]};
  endfunction

  function automatic logic [71:0] beat1_of(input logic [103:0] t);
    logic [31:0] data, src;
    data = t[63:32]; src = t[31:0];
    return {8'hFF, data[7:0], src, 24'h0};
  endfunction

  typedef struct {
    logic         rst, w, a, b;
    logic [103:0] ta, tb;
    logic         er0, er1;
    logic [71:0]  eout;
    logic         ebusy;
    logic [15:0]  ecnt;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic w, input logic a, input logic b,
                              input logic [103:0] ta, input logic [103:0] tb_,
                              input logic er0, input logic er1, input logic [71:0] eout,
                              input logic ebusy, input logic [15:0] ecnt);
    vec_t v;
    v.rst = r; v.w = w; v.a = a; v.b = b; v.ta = ta; v.tb = tb_;
    v.er0 = er0; v.er1 = er1; v.eout = eout; v.ebusy = ebusy; v.ecnt = ecnt;
    return v;
  endfunction

  // Reference model: a queue of pending words plus a count of busy cycles left.
  logic [71:0] m_pend[$];
  logic [71:0] m_out;
  int          m_busy_left;
  logic [15:0] m_cnt;
  int          m_pref;
  int          m_win;

  task automatic model_predict();
    m_win = -1;
    if (!rst && m_busy_left == 0 && !tx_wait && (v0 || v1))
      m_win = (v0 && v1) ? m_pref : (v1 ? 1 : 0);
  endtask

  task automatic model_edge();
    logic [103:0] t;
    if (rst) begin
      m_pend.delete(); m_out = '0; m_busy_left = 0; m_cnt = '0; m_pref = 0;
    end else if (m_win >= 0) begin
      t = (m_win == 1) ? t1 : t0;
      m_out = beat0_of(t);
      m_pend.push_back(beat1_of(t));
      m_busy_left = 2;
      m_cnt = m_cnt + 16'd1;
      m_pref = 1 - m_win;
    end else if (m_pend.size() > 0) begin
      m_out = m_pend.pop_front();
      m_busy_left--;
    end else begin
      m_out = '0;
      if (m_busy_left > 0) m_busy_left--;
    end
  endtask

  localparam logic [103:0] TA = {8'hA5, 32'h8000_0010, 32'hDEAD_BEEF, 32'h1234_5678};
  localparam logic [103:0] TB = {8'h5A, 32'h0000_1000, 32'hCAFE_F00D, 32'h0BAD_0001};
  localparam logic [71:0]  A0 = {8'h3F, 8'hA5, 32'h8000_0010, 24'hDEAD_BE};
  localparam logic [71:0]  A1 = {8'hFF, 8'hEF, 32'h1234_5678, 24'h0};
  localparam logic [71:0]  B0 = {8'h3F, 8'h5A, 32'h0000_1000, 24'hCAFE_F0};
  localparam logic [71:0]  B1 = {8'hFF, 8'h0D, 32'h0BAD_0001, 24'h0};

  vec_t vecs[16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_idx[$];
    int acc_id[$];
    int coincide;
    logic [127:0] rnd;

    //            rst w  v0 v1 TRAN0 TRAN1 R0 R1 word  busy cnt
    vecs[0]  = mk(1, 0, 0, 0, TA, TB, 0, 0, 72'h0, 0, 16'd0);
    vecs[1]  = mk(0, 0, 1, 0, TA, TB, 1, 0, A0,    1, 16'd1);
    vecs[2]  = mk(0, 0, 0, 0, 0,  0,  0, 0, A1,    1, 16'd1);
    vecs[3]  = mk(0, 0, 0, 0, 0,  0,  0, 0, 72'h0, 0, 16'd1);
    vecs[4]  = mk(0, 1, 0, 1, TA, TB, 0, 0, 72'h0, 0, 16'd1);
    vecs[5]  = mk(0, 1, 0, 1, TA, TB, 0, 0, 72'h0, 0, 16'd1);
    vecs[6]  = mk(0, 0, 0, 1, TA, TB, 0, 1, B0,    1, 16'd2);
    vecs[7]  = mk(0, 1, 0, 1, 0,  0,  0, 0, B1,    1, 16'd2);
    vecs[8]  = mk(0, 1, 0, 1, 0,  0,  0, 0, 72'h0, 0, 16'd2);
    vecs[9]  = mk(0, 0, 1, 0, TA, TB, 1, 0, A0,    1, 16'd3);
    vecs[10] = mk(1, 0, 1, 1, TA, TB, 0, 0, 72'h0, 0, 16'd0);
    vecs[11] = mk(0, 0, 1, 1, TA, TB, 1, 0, A0,    1, 16'd1);
    vecs[12] = mk(0, 0, 1, 1, TA, TB, 0, 0, A1,    1, 16'd1);
    vecs[13] = mk(0, 0, 1, 1, TA, TB, 0, 0, 72'h0, 0, 16'd1);
    vecs[14] = mk(0, 0, 1, 1, TA, TB, 0, 1, B0,    1, 16'd2);
    vecs[15] = mk(1, 0, 1, 0, TA, TB, 0, 0, 72'h0, 0, 16'd0);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].ta, vecs[i].tb);
      #1;
      check($sformatf("vec%0d ready0", i), 72'(r0), 72'(vecs[i].er0));
      check($sformatf("vec%0d ready1", i), 72'(r1), 72'(vecs[i].er1));
      @(posedge clk); #1;
      check($sformatf("vec%0d data_out", i), dout, vecs[i].eout);
      check($sformatf("vec%0d busy", i), 72'(busy), 72'(vecs[i].ebusy));
      check($sformatf("vec%0d tx_count", i), 72'(cnt), 72'(vecs[i].ecnt));
      @(negedge clk);
    end

    // Contention: both requesters held for 12 cycles straight after reset.
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk); @(negedge clk);
    coincide = 0;
    for (int c = 0; c < 12; c++) begin
      drive(0, 0, 1, 1, TA, TB);
      #1;
      if (r0 && r1) coincide++;
      if (r0) begin acc_idx.push_back(c); acc_id.push_back(0); end
      if (r1) begin acc_idx.push_back(c); acc_id.push_back(1); end
      @(negedge clk);
    end
    check("contention coincident_ready", 72'(coincide), 72'(0));
    check("contention accept_count", 72'(acc_idx.size()), 72'(4));
    for (int k = 0; k < 4; k++) begin
      if (k < acc_idx.size()) begin
        check($sformatf("contention accept%0d cycle", k), 72'(acc_idx[k]), 72'(3 * k));
        check($sformatf("contention accept%0d id", k), 72'(acc_id[k]), 72'(k % 2));
      end
    end

    // Wrap: preload TX_COUNT to all-ones, then one accept.
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk); @(negedge clk);
    drive(0, 0, 1, 0, TA, TB);
    force dut.tx_count_q = 16'hFFFF;
    #1;
    release dut.tx_count_q;
    #1;
    check("wrap preload", 72'(cnt), 72'(16'hFFFF));
    check("wrap ready0", 72'(r0), 72'(1));
    @(posedge clk); #1;
    check("wrap tx_count", 72'(cnt), 72'(16'h0000));
    @(negedge clk);

    // Randomized run against the reference model.
    for (int n = 0; n < 3000; n++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      t0 = rnd[103:0];
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      t1 = rnd[103:0];
      rst     = (n == 0) || ($urandom_range(0, 63) == 0);
      tx_wait = ($urandom_range(0, 3) == 0);
      v0      = $urandom_range(0, 1) == 1;
      v1      = $urandom_range(0, 1) == 1;
      #1;
      model_predict();
      check($sformatf("rand%0d ready0", n), 72'(r0), 72'(m_win == 0));
      check($sformatf("rand%0d ready1", n), 72'(r1), 72'(m_win == 1));
      @(posedge clk);
      model_edge();
      #1;
      check($sformatf("rand%0d data_out", n), dout, m_out);
      check($sformatf("rand%0d busy", n), 72'(busy), 72'(m_busy_left > 0));
      check($sformatf("rand%0d tx_count", n), 72'(cnt), 72'(m_cnt));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
